// File: rtl/vm_pkg.sv
// Shared constants for the vending-machine input conditioner: debounce lengths
// and the channel index map used by the top level.
package vm_pkg;

  localparam int DEFAULT_DEBOUNCE_CYC = 1_000_000;
  localparam int SIM_DEBOUNCE_CYC     = 4;
  localparam int NUM_CH               = 3;

  typedef enum logic [1:0] {
    CH_COIN   = 2'd0,
    CH_COFFEE = 2'd1,
    CH_SPRITE = 2'd2
  } ch_idx_e;

endpackage

// File: rtl/vm_debounce_ch.sv
// One conditioner channel: two-flop synchroniser, stable-count debouncer and
// a single-cycle pulse on each accepted press (debounced 0->1).
module vm_debounce_ch
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             meta_q;
  logic             sync_q;
  logic             db_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // A change is accepted only after DEBOUNCE_CYC consecutive differing samples;
  // any matching sample restarts the count, so the counter can never wrap.
  assign accept = (sync_q != db_q) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= 1'b0;
      cnt  <= '0;
    end else if (sync_q == db_q) begin
      cnt <= '0;
    end else if (accept) begin
      db_q <= sync_q;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= 1'b0;
    end else begin
      pulse <= accept && sync_q;
    end
  end

endmodule

// File: rtl/vm_input_conditioner.sv
// Vending-machine front end: polarity fix-up plus three debounce channels.
// Optional VM_BTN_INTERLOCK_EN suppresses simultaneous coffee/sprite presses.
module vm_input_conditioner
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEFAULT_DEBOUNCE_CYC,
  parameter bit IN_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_coin_raw,
  input  logic i_coffee_raw,
  input  logic i_sprite_raw,
  output logic o_coin,
  output logic o_coffee,
  output logic o_sprite
`ifdef VM_BTN_INTERLOCK_EN
  ,
  output logic o_conflict
`endif
);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] cond_vec;
  logic [NUM_CH-1:0] pulse_vec;

  assign raw_vec[CH_COIN]   = i_coin_raw;
  assign raw_vec[CH_COFFEE] = i_coffee_raw;
  assign raw_vec[CH_SPRITE] = i_sprite_raw;

  // Pressed-low boards are normalised before the synchroniser so that the
  // reset value of every channel means "released".
  assign cond_vec = IN_ACTIVE_LOW ? ~raw_vec : raw_vec;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    vm_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (cond_vec[ch]),
      .pulse(pulse_vec[ch])
    );
  end

  assign o_coin = pulse_vec[CH_COIN];

`ifdef VM_BTN_INTERLOCK_EN
  logic clash;

  // Both drink pulses come from flops, so a same-edge clash is seen here as
  // both being high together; each channel has already latched its press.
  assign clash      = pulse_vec[CH_COFFEE] & pulse_vec[CH_SPRITE];
  assign o_coffee   = pulse_vec[CH_COFFEE] & ~clash;
  assign o_sprite   = pulse_vec[CH_SPRITE] & ~clash;
  assign o_conflict = clash;
`else
  assign o_coffee = pulse_vec[CH_COFFEE];
  assign o_sprite = pulse_vec[CH_SPRITE];
`endif

endmodule

// File: tb/tb_vm_input_conditioner.sv
// Self-checking bench for vm_input_conditioner: window-based reference model,
// per-cycle output compare, directed scenarios with literal latency checks, random phase.
module tb_vm_input_conditioner;
  import vm_pkg::*;

  localparam int DC = SIM_DEBOUNCE_CYC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw;
  logic       o_coin;
  logic       o_coffee;
  logic       o_sprite;
`ifdef VM_BTN_INTERLOCK_EN
  logic       o_conflict;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #10 clk = ~clk;

  vm_input_conditioner #(
    .DEBOUNCE_CYC (DC),
    .IN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_coin_raw  (raw[0]),
    .i_coffee_raw(raw[1]),
    .i_sprite_raw(raw[2]),
    .o_coin      (o_coin),
    .o_coffee    (o_coffee),
`ifdef VM_BTN_INTERLOCK_EN
    .o_sprite    (o_sprite),
    .o_conflict  (o_conflict)
`else
    .o_sprite    (o_sprite)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the last DC synchronised samples
  // all disagree with the accepted level; synchronised input is raw delayed 2 edges.
  int dly[3][$];
  int win[3][$];
  bit db[3];
  bit exp_out[4];
  int m_cnt[4]  = '{default: 0};
  int m_last[4] = '{default: -1};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        dly[ch].delete();
        dly[ch].push_back(0);
        dly[ch].push_back(0);
        win[ch].delete();
        db[ch] = 1'b0;
      end
      for (int k = 0; k < 4; k++) exp_out[k] = 1'b0;
    end else begin
      bit rise[3];
      bit clash;
      for (int ch = 0; ch < 3; ch++) begin
        int s;
        bit all_diff;
        s = dly[ch].pop_front();
        dly[ch].push_back(int'(raw[ch]));
        win[ch].push_back(s);
        if (win[ch].size() > DC) void'(win[ch].pop_front());
        rise[ch] = 1'b0;
        if (win[ch].size() == DC) begin
          all_diff = 1'b1;
          foreach (win[ch][i]) if (win[ch][i] == int'(db[ch])) all_diff = 1'b0;
          if (all_diff) begin
            db[ch]   = !db[ch];
            rise[ch] = db[ch];
          end
        end
      end
      clash = 1'b0;
`ifdef VM_BTN_INTERLOCK_EN
      clash = rise[1] && rise[2];
      if (clash) begin
        rise[1] = 1'b0;
        rise[2] = 1'b0;
      end
`endif
      for (int ch = 0; ch < 3; ch++) exp_out[ch] = rise[ch];
      exp_out[3] = clash;
      for (int k = 0; k < 4; k++) begin
        if (exp_out[k]) begin
          m_cnt[k]++;
          m_last[k] = cyc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check_output($sformatf("o_coin@%0d", cyc),   int'(o_coin),   int'(exp_out[0]));
    check_output($sformatf("o_coffee@%0d", cyc), int'(o_coffee), int'(exp_out[1]));
    check_output($sformatf("o_sprite@%0d", cyc), int'(o_sprite), int'(exp_out[2]));
`ifdef VM_BTN_INTERLOCK_EN
    check_output($sformatf("o_conflict@%0d", cyc), int'(o_conflict), int'(exp_out[3]));
`endif
  end

  // Drives a raw pattern for n cycles; e is the first clock edge that sees it.
  task automatic apply_stimulus(input logic [2:0] v, input int n, output int e);
    @(negedge clk);
    raw = v;
    e   = cyc + 1;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int e, e2, r;
    int c0, c1, c2, c3;
    logic [2:0] rnd;

    rst_n = 1'b1;
    raw   = 3'b000;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset
    repeat (20) @(negedge clk);
    check_output("idle_coin_cnt", m_cnt[0], 0);
    check_output("idle_coffee_cnt", m_cnt[1], 0);
    check_output("idle_sprite_cnt", m_cnt[2], 0);

    // Coin press and release
    c0 = m_cnt[0];
    apply_stimulus(3'b001, 12, e);
    apply_stimulus(3'b000, 12, e2);
    check_output("coin_cnt", m_cnt[0] - c0, 1);
    check_output("coin_edge", m_last[0], e + 5);

    // Coffee glitch then bounce into steady press
    c1 = m_cnt[1];
    apply_stimulus(3'b010, 3, e);
    apply_stimulus(3'b000, 8, e);
    check_output("glitch_cnt", m_cnt[1] - c1, 0);
    apply_stimulus(3'b000, 1, e);
    apply_stimulus(3'b010, 1, e);
    apply_stimulus(3'b000, 1, e);
    apply_stimulus(3'b010, 11, e);
    apply_stimulus(3'b000, 10, e2);
    check_output("bounce_cnt", m_cnt[1] - c1, 1);
    check_output("bounce_edge", m_last[1], e + 5);

    // Sprite held, released, re-pressed
    c2 = m_cnt[2];
    apply_stimulus(3'b100, 20, e);
    check_output("sprite_first_edge", m_last[2], e + 5);
    apply_stimulus(3'b000, 6, e2);
    apply_stimulus(3'b100, 8, e);
    apply_stimulus(3'b000, 10, e2);
    check_output("sprite_cnt", m_cnt[2] - c2, 2);
    check_output("sprite_second_edge", m_last[2], e + 5);

    // Coffee and sprite together
    c1 = m_cnt[1];
    c2 = m_cnt[2];
    c3 = m_cnt[3];
    apply_stimulus(3'b110, 8, e);
    apply_stimulus(3'b000, 10, e2);
`ifdef VM_BTN_INTERLOCK_EN
    check_output("both_coffee_cnt", m_cnt[1] - c1, 0);
    check_output("both_sprite_cnt", m_cnt[2] - c2, 0);
    check_output("both_conflict_cnt", m_cnt[3] - c3, 1);
    check_output("both_conflict_edge", m_last[3], e + 5);
`else
    check_output("both_coffee_edge", m_last[1], e + 5);
    check_output("both_sprite_edge", m_last[2], e + 5);
    check_output("both_conflict_cnt", m_cnt[3] - c3, 0);
`endif

    // Reset in the middle of a coin debounce
    c0 = m_cnt[0];
    apply_stimulus(3'b001, 3, e);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_no_early_pulse", m_cnt[0] - c0, 0);
    #2 rst_n = 1'b1;
    r = cyc + 1;
    apply_stimulus(3'b001, 10, e);
    apply_stimulus(3'b000, 10, e2);
    check_output("rst_coin_cnt", m_cnt[0] - c0, 1);
    check_output("rst_coin_edge", m_last[0], r + 5);

    // Random phase: independent toggling channels with occasional resets
    rnd = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < 3; ch++) begin
        if ($urandom_range(0, 4) == 0) rnd[ch] = ~rnd[ch];
      end
      raw = rnd;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    apply_stimulus(3'b000, 12, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
